// File: rtl/fifo_read_ctrl_if.sv
// Read-side memory and consumer stream bundle for fifo_read_ctrl.
// master = controller side, slave = memory/consumer side.
interface fifo_read_ctrl_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  ren;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;

  modport master (
    output raddr, ren, dout, dout_valid,
    input  rdata, dout_ready
  );

  modport slave (
    input  raddr, ren, dout, dout_valid,
    output rdata, dout_ready
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller for the dual-clock FIFO: wptr sync, read pointer, empty, 2-entry output buffer.
// Optional registered occupancy output rlevel when FIFO_RD_LEVEL_EN is defined.
module fifo_read_ctrl #(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDR_WIDTH:0] wptr_gray,
  output logic [ADDR_WIDTH:0] rptr_gray,
  output logic                empty,
`ifdef FIFO_RD_LEVEL_EN
  output logic [ADDR_WIDTH:0] rlevel,
`endif
  fifo_read_ctrl_if.master    rd
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         sync_q [SYNC_STAGES];
  logic [PW-1:0]         wq;
  logic [PW-1:0]         rptr_bin;
  logic [PW-1:0]         rptr_bin_next;
  logic [PW-1:0]         rptr_gray_next;
  logic                  inflight;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  head;
  logic                  tail;
  logic                  pop;
  logic                  bypass;
  logic                  push;
  logic                  drop;
  logic                  issue;

  assign wq = sync_q[SYNC_STAGES-1];

  always_ff @(posedge rclk) begin
    if (rrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= wptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // A word still in flight with an empty buffer is forwarded straight from
  // rdata so the consumer sees it one cycle after ren.
  assign rd.dout_valid = (occ != 2'd0) | inflight;
  assign rd.dout       = (occ != 2'd0) ? buf_q[head] :
                         (inflight ? rd.rdata : '0);

  assign pop    = rd.dout_valid & rd.dout_ready;
  assign bypass = pop & (occ == 2'd0);
  assign push   = inflight & ~bypass;
  assign drop   = pop & (occ != 2'd0);

  assign issue = ~empty &
                 (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  assign rd.ren   = issue;
  assign rd.raddr = rptr_bin[ADDR_WIDTH-1:0];

  assign rptr_bin_next  = rptr_bin + {{(PW-1){1'b0}}, issue};
  assign rptr_gray_next = rptr_bin_next ^ (rptr_bin_next >> 1);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rptr_bin  <= '0;
      rptr_gray <= '0;
      empty     <= 1'b1;
      inflight  <= 1'b0;
      occ       <= 2'd0;
      head      <= 1'b0;
      tail      <= 1'b0;
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
    end else begin
      rptr_bin  <= rptr_bin_next;
      rptr_gray <= rptr_gray_next;
      empty     <= (rptr_gray_next == wq);
      inflight  <= issue;
      if (push) begin
        buf_q[tail] <= rd.rdata;
        tail        <= ~tail;
      end
      if (drop) head <= ~head;
      occ <= occ + {1'b0, push} - {1'b0, drop};
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_ff @(posedge rclk) begin
    if (rrst) rlevel <= '0;
    else      rlevel <= gray2bin(wq) - rptr_bin;
  end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a 1-cycle-latency memory model.
`timescale 1ns/1ps
module tb_fifo_read_ctrl;
  localparam int DW = 4;
  localparam int AW = 4;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rrst;
  logic [AW:0]   wptr_gray;
  logic [AW:0]   rptr_gray;
  logic          empty;
`ifdef FIFO_RD_LEVEL_EN
  logic [AW:0]   rlevel;
`endif
  logic [DW-1:0] mem [16];
  int            checks = 0;
  int            errors = 0;

  fifo_read_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_read_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SS)) dut (
    .rclk      (clk),
    .rrst      (rrst),
    .wptr_gray (wptr_gray),
    .rptr_gray (rptr_gray),
    .empty     (empty),
`ifdef FIFO_RD_LEVEL_EN
    .rlevel    (rlevel),
`endif
    .rd        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.rdata <= bus.ren ? mem[bus.raddr] : '0;

  typedef struct {
    logic          ready;
    logic [AW:0]   wptr;
    logic          e_empty;
    logic          e_ren;
    logic [AW-1:0] e_raddr;
    logic          e_dv;
    logic [DW-1:0] e_dout;
    logic [AW:0]   e_rptr;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    wptr_gray = '0;
    bus.dout_ready = 1'b0;
    tick();
    rrst = 1'b0;
  endtask

  initial begin
    int nren;
    vecs[0] = '{1'b1, 5'h01, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 5'h00};
    vecs[1] = '{1'b1, 5'h01, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 5'h00};
    vecs[2] = '{1'b1, 5'h01, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 5'h00};
    vecs[3] = '{1'b1, 5'h01, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 5'h00};
    vecs[4] = '{1'b1, 5'h01, 1'b1, 1'b0, 4'h1, 1'b1, 4'hA, 5'h01};
    vecs[5] = '{1'b1, 5'h01, 1'b1, 1'b0, 4'h1, 1'b0, 4'h0, 5'h01};

    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 4'hA;
    rrst = 1'b1;
    wptr_gray = '0;
    bus.dout_ready = 1'b0;
    tick();
    do_reset();

    for (int c = 0; c < 20; c++) begin
      check("idle empty", 32'(empty), 32'd1);
      check("idle ren", 32'(bus.ren), 32'd0);
      check("idle dout_valid", 32'(bus.dout_valid), 32'd0);
      check("idle rptr_gray", 32'(rptr_gray), 32'd0);
      tick();
    end

    for (int i = 0; i < 6; i++) begin
      bus.dout_ready = vecs[i].ready;
      wptr_gray = vecs[i].wptr;
      #1;
      check($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].e_empty));
      check($sformatf("vec%0d ren", i), 32'(bus.ren), 32'(vecs[i].e_ren));
      check($sformatf("vec%0d raddr", i), 32'(bus.raddr), 32'(vecs[i].e_raddr));
      check($sformatf("vec%0d dout_valid", i), 32'(bus.dout_valid), 32'(vecs[i].e_dv));
      check($sformatf("vec%0d dout", i), 32'(bus.dout), 32'(vecs[i].e_dout));
      check($sformatf("vec%0d rptr_gray", i), 32'(rptr_gray), 32'(vecs[i].e_rptr));
      tick();
    end

    // Full 16-word stream with the consumer always ready.
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    wptr_gray = 5'h18;
    bus.dout_ready = 1'b1;
    repeat (3) tick();
    check("stream first ren", 32'(bus.ren), 32'd1);
    check("stream first raddr", 32'(bus.raddr), 32'd0);
    tick();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("stream dv%0d", k), 32'(bus.dout_valid), 32'd1);
      check($sformatf("stream dout%0d", k), 32'(bus.dout), 32'(k));
      if (k < 15) check($sformatf("stream ren%0d", k), 32'(bus.ren), 32'd1);
      if (k == 14) check("stream raddr 15", 32'(bus.raddr), 32'd15);
      if (k == 15) begin
        check("stream raddr wrap", 32'(bus.raddr), 32'd0);
        check("stream ren stop", 32'(bus.ren), 32'd0);
        check("stream rptr_gray", 32'(rptr_gray), 32'h18);
        check("stream empty", 32'(empty), 32'd1);
      end
      tick();
    end
    check("stream drained", 32'(bus.dout_valid), 32'd0);

    // Backpressure: only two reads issue until the consumer becomes ready.
    do_reset();
    wptr_gray = 5'h18;
    repeat (3) tick();
    nren = 0;
    for (int i = 0; i < 10; i++) begin
      nren += int'(bus.ren);
      if (i > 0) begin
        check("bp dout_valid", 32'(bus.dout_valid), 32'd1);
        check("bp dout held", 32'(bus.dout), 32'd0);
      end
      tick();
    end
    check("bp ren pulses", 32'(nren), 32'd2);
    check("bp rptr_gray", 32'(rptr_gray), 32'h03);
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("bp dv%0d", k), 32'(bus.dout_valid), 32'd1);
      check($sformatf("bp dout%0d", k), 32'(bus.dout), 32'(k));
      tick();
    end
    check("bp drained", 32'(bus.dout_valid), 32'd0);
    check("bp empty", 32'(empty), 32'd1);
    check("bp rptr_end", 32'(rptr_gray), 32'h18);

    // Reset while a read is in flight: returned data must be dropped.
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 4'(15 - i);
    wptr_gray = 5'h18;
    repeat (3) tick();
    check("rst pre ren", 32'(bus.ren), 32'd1);
    tick();
    rrst = 1'b1;
    tick();
    rrst = 1'b0;
    check("rst empty", 32'(empty), 32'd1);
    check("rst ren", 32'(bus.ren), 32'd0);
    check("rst raddr", 32'(bus.raddr), 32'd0);
    check("rst dout_valid", 32'(bus.dout_valid), 32'd0);
    check("rst dout", 32'(bus.dout), 32'd0);
    check("rst rptr_gray", 32'(rptr_gray), 32'd0);
    bus.dout_ready = 1'b1;
    repeat (3) tick();
    check("rst restart ren", 32'(bus.ren), 32'd1);
    check("rst restart raddr", 32'(bus.raddr), 32'd0);
    tick();
    check("rst restart dv", 32'(bus.dout_valid), 32'd1);
    check("rst restart dout", 32'(bus.dout), 32'hF);

`ifdef FIFO_RD_LEVEL_EN
    do_reset();
    check("lvl reset", 32'(rlevel), 32'd0);
    wptr_gray = 5'h07;
    bus.dout_ready = 1'b1;
    repeat (3) tick();
    check("lvl sync", 32'(rlevel), 32'd5);
    tick();
    check("lvl hold", 32'(rlevel), 32'd5);
    for (int k = 4; k >= 0; k--) begin
      tick();
      check($sformatf("lvl %0d", k), 32'(rlevel), 32'(k));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
- Read-side controller for the dual-clock 4-bit FIFO. Lives entirely in the read clock domain.
- Synchronises the write-domain Gray write pointer, maintains the read pointer, and generates the empty flag.
- Drives raddr/ren into the FIFO memory and captures its 1-cycle-latency rdata into a 2-entry output buffer.
- Presents the data to the consumer as a valid/ready stream at up to 1 word/cycle.

Parameters:
- DATA_WIDTH, 4, width of memory read data and of dout.
- ADDR_WIDTH, 4, memory address width; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- SYNC_STAGES, 2, flops in the wptr synchroniser chain; legal values ≥2.

Ports:
- rclk  in  1  read-domain clock; all logic on posedge.
- rrst  in  1  synchronous active-high reset.
- wptr_gray  in  ADDR_WIDTH+1  Gray-coded write pointer from the write domain; asynchronous to rclk.
- rptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain for full detection.
- raddr  out  ADDR_WIDTH  memory read address; equals the low ADDR_WIDTH bits of the binary read pointer.
- ren  out  1  memory read enable; one pulse per word.
- rdata  in  DATA_WIDTH  memory read data; valid the cycle after ren=1, and zero otherwise.
- dout  out  DATA_WIDTH  head-of-buffer data.
- dout_valid  out  1  dout holds a word.
- dout_ready  in  1  consumer accepts dout this cycle.
- empty  out  1  registered: no unread words in memory (excludes buffered words).

Behaviour:
- Reset (rrst=1 at posedge): all outputs and state are cleared.
  - Binary and Gray read pointers = 0; synchroniser flops = 0; empty=1; ren=0; raddr=0.
  - Buffer occupancy occ=0; inflight=0; dout_valid=0; dout=0.
  - A read in flight at reset is discarded: the rdata arriving the next cycle is ignored because inflight=0.
- Synchroniser: wptr_gray passes through SYNC_STAGES flops to give wq. No other logic samples wptr_gray directly.
- pop = dout_valid & dout_ready.
- Issue rule: ren = !empty & (occ + inflight - pop < 2). ren is combinational from registers plus dout_ready.
  - ren=1: memory reads raddr.
  - Next cycle: binary pointer increments, Gray pointer = bin^(bin>>1), inflight=1.
  - ren=0: inflight=0 next cycle.
- Empty: registered, computed from the next-state Gray read pointer.
  - empty_next = (rptr_gray_next == wq).
  - empty therefore deasserts SYNC_STAGES+1 rclk cycles after wptr_gray changes.
- Capture: when inflight=1, rdata is written into the 2-entry FIFO buffer. When inflight=0, rdata is ignored.
  - Capture and pop in the same cycle: occ unchanged, order preserved.
  - occ never exceeds 2. The issue rule guarantees this; an overflow is a design error.
- Output: dout/dout_valid come from the buffer head.
  - dout holds stable while dout_valid=1 & dout_ready=0.
  - Latency from the ren cycle to dout_valid is 1 cycle when the buffer is empty.
- Throughput: with dout_ready held high and a non-empty memory, ren stays 1 every cycle and dout_valid stays 1 continuously.
- Wrap-around: raddr wraps from 2**ADDR_WIDTH-1 to 0. The pointer MSB toggles, and full/empty stay unambiguous through the extra pointer bit.
- Gray pointer changes by exactly 1 bit per increment. rptr_gray is a direct flop output with no combinational path.

Optional Feature:
- Macro FIFO_RD_LEVEL_EN.
- Defined:
  - Adds output rlevel, ADDR_WIDTH+1 bits, registered.
  - rlevel = gray2bin(wq) - rptr_bin, modulo 2**(ADDR_WIDTH+1). This is the conservative count of unread memory words.
  - rlevel resets to 0 and updates every cycle.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle, wptr_gray=0: empty=1, ren=0, dout_valid=0, rptr_gray=0 for 20 cycles.
- Write side advances wptr_gray 0→1 (data 0xA at addr 0) with dout_ready=1:
  - empty falls SYNC_STAGES+1 cycles later.
  - ren pulses once with raddr=0; dout=0xA, dout_valid=1 the next cycle.
  - rptr_gray=1 afterwards; empty returns to 1.
- Memory preloaded with 16 words 0..F, wptr_gray=gray(16)=0x18, dout_ready=1:
  - dout streams 0..F on consecutive cycles; raddr wraps 15→0.
  - rptr_gray ends at 0x18; empty=1.
- Same preload with dout_ready=0:
  - exactly 2 ren pulses; occ=2; dout=0 held; no further ren.
  - Raise dout_ready: remaining words 2..F follow in order, with no loss or duplication.
- rrst asserted the cycle after a ren pulse: the returned rdata is discarded; all outputs equal reset values the next cycle; pointers restart at 0.
- FIFO_RD_LEVEL_EN defined, preload 5 words: rlevel=5 after synchronisation, then decrements by 1 per ren, reaching 0.
